lc3_mem_initiator: RTL
======================

// Module: lc3_mem_initiator
// PURPOSE
//  Initiator-side sequencer for the LC3 MAR/MDR memory. Takes one read or write request
//  at a time and drives the memory's Buss, ldMAR, ldMDR, selMDR and memWE strobes.
//  Returns read data or write completion to the datapath/fetch logic as a one-cycle
//  response pulse.
//  Sits between the LC3 control unit and the Memory block; it is the only driver of
//  memory strobes.
// PARAMETERS
//  MEM_DEPTH  256  number of implemented words; req_addr >= MEM_DEPTH is an error
//  MEM_WAIT   0    extra idle cycles between MAR load and MDR load on reads (0..15)
// PORTS
//  clk        in   1   single clock; all state changes on posedge
//  reset      in   1   asynchronous, active-high reset
//  req_valid  in   1   request present
//  req_ready  out  1   high only in IDLE with reset low; accept = req_valid & req_ready
//  req_we     in   1   1 = write, 0 = read
//  req_addr   in   16  word address
//  req_wdata  in   16  write data
//  rsp_valid  out  1   one-cycle completion pulse; no backpressure
//  rsp_rdata  out  16  read data, valid only while rsp_valid & read & !rsp_err; else 0
//  rsp_err    out  1   with rsp_valid: address out of range, no memory access made
//  bus_out    out  16  value for Buss; 0 when bus_drive = 0
//  bus_drive  out  1   tristate/mux enable onto Buss
//  ldMAR      out  1   load MAR from Buss
//  ldMDR      out  1   load MDR
//  selMDR     out  1   1 = MDR from memOut, 0 = MDR from Buss
//  memWE      out  1   write mdrOut into memory at MAR
//  mdrOut     in   16  MDR contents from the Memory block
// BEHAVIOUR
//  - Accept: latch req_we, req_addr and req_wdata; input changes have no effect until
//    the next IDLE.
//  - States: IDLE, LDMAR, WAIT, LDMDR, WRITE, RESP, ERR. Outputs decode from state and
//    latched regs.
//  - IDLE:
//    - On accept with addr >= MEM_DEPTH: go to ERR. No strobe is ever asserted.
//    - On any other accept: go to LDMAR.
//  - LDMAR: bus_out = addr, bus_drive = 1, ldMAR = 1.
//    - Read: go to WAIT if MEM_WAIT > 0, else to LDMDR.
//    - Write: go to LDMDR.
//  - WAIT: 4-bit down-counter loaded with MEM_WAIT-1 on entry. All strobes 0. Go to
//    LDMDR when the count reaches 0.
//  - LDMDR: ldMDR = 1.
//    - Read: selMDR = 1, bus_drive = 0, then go to RESP.
//    - Write: selMDR = 0, bus_out = wdata, bus_drive = 1, then go to WRITE.
//  - WRITE: memWE = 1 for exactly one cycle (mdrOut already equals wdata). Go to RESP.
//  - RESP: rsp_valid = 1.
//    - Read: rsp_rdata = mdrOut.
//    - Go to IDLE.
//  - ERR: rsp_valid = 1 and rsp_err = 1, then go to IDLE. Replaces RESP on the error
//    path.
//  - Latency, counting the accept cycle as 0:
//    - Read: LDMAR in 1, LDMDR in 2+MEM_WAIT, rsp_valid in 3+MEM_WAIT.
//    - Write: LDMAR in 1, LDMDR in 2, memWE in 3, rsp_valid in 4.
//    - Error: rsp_valid in 1.
//  - Back-to-back: req_ready is 0 from cycle 1 through the RESP cycle. The next accept
//    is possible in the cycle after RESP. Min spacing: 4+W (read), 5 (write), 2 (error).
//  - At most one of ldMAR, ldMDR, memWE is high in any cycle. bus_drive is never high
//    together with selMDR.
//  - Reset (any time, including mid-transaction):
//    - Immediately: state = IDLE; all outputs 0 (req_ready is also 0 while reset is
//      high); latched regs and counter = 0.
//    - An in-flight write whose memWE cycle has not occurred is dropped with no
//      response.
//    - req_ready returns to 1 in the first cycle after reset deasserts.
//  - Address compare is unsigned and uses all 16 bits.
// TESTING
//  1 Reset held 3 cycles, then released -> all strobes/rsp 0 during reset; req_ready=1
//    in the first cycle after release.
//  2 Write addr 0x0012, data 0xBEEF -> ldMAR@1 with bus 0x0012; ldMDR@2 selMDR=0 bus
//    0xBEEF; memWE@3; rsp_valid@4, rsp_err=0.
//  3 Read 0x0012 after test 2, MEM_WAIT=0 -> ldMAR@1, ldMDR+selMDR@2, rsp_valid@3 with
//    rsp_rdata=0xBEEF. Repeat with MEM_WAIT=2 -> rsp_valid@5.
//  4 Read addr 0x0100 (MEM_DEPTH=256) -> rsp_valid=1, rsp_err=1 @1; no ldMAR/ldMDR/memWE
//    ever. A following request is accepted @2.
//  5 req_valid held high with alternating write/read to 0x00FF -> no accept while busy;
//    strobe exclusivity assertion never fires; read returns the written value.
//  6 Write 0x0001 and assert reset in cycle 2 -> outputs 0 at once; memWE never pulses;
//    no rsp_valid; next read of 0x0001 returns the pre-test content.

Source files
------------

// File: rtl/lc3_mem_initiator.sv
// rtl/lc3_mem_initiator.sv - request sequencer driving LC3 MAR/MDR memory strobes
// Accepts one read/write request at a time and returns a one-cycle response pulse.
module lc3_mem_initiator #(
  parameter int MEM_DEPTH = 256,
  parameter int MEM_WAIT  = 0
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [15:0] req_addr,
  input  logic [15:0] req_wdata,
  output logic        rsp_valid,
  output logic [15:0] rsp_rdata,
  output logic        rsp_err,
  output logic [15:0] bus_out,
  output logic        bus_drive,
  output logic        ldMAR,
  output logic        ldMDR,
  output logic        selMDR,
  output logic        memWE,
  input  logic [15:0] mdrOut
);

  typedef enum logic [2:0] {
    S_IDLE, S_LDMAR, S_WAIT, S_LDMDR, S_WRITE, S_RESP, S_ERR
  } state_t;

  localparam logic [16:0] DEPTH     = 17'(MEM_DEPTH);
  localparam logic [3:0]  WAIT_INIT = 4'((MEM_WAIT > 0) ? (MEM_WAIT - 1) : 0);

  state_t      state, state_nx;
  logic        we_q;
  logic [15:0] addr_q, wdata_q;
  logic [3:0]  cnt, cnt_nx;
  logic        accept;
  logic        addr_err;

  // Full 16-bit unsigned compare; one extra bit lets MEM_DEPTH reach 65536.
  assign addr_err = ({1'b0, req_addr} >= DEPTH);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      we_q    <= 1'b0;
      addr_q  <= 16'h0000;
      wdata_q <= 16'h0000;
      cnt     <= 4'd0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    accept    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    rsp_rdata = 16'h0000;
    rsp_err   = 1'b0;
    bus_out   = 16'h0000;
    bus_drive = 1'b0;
    ldMAR     = 1'b0;
    ldMDR     = 1'b0;
    selMDR    = 1'b0;
    memWE     = 1'b0;
    case (state)
      S_IDLE: begin
        req_ready = !reset;
        accept    = req_valid && !reset;
        if (accept) state_nx = addr_err ? S_ERR : S_LDMAR;
      end
      S_LDMAR: begin
        bus_out   = addr_q;
        bus_drive = 1'b1;
        ldMAR     = 1'b1;
        if (!we_q && (MEM_WAIT > 0)) begin
          state_nx = S_WAIT;
          cnt_nx   = WAIT_INIT;
        end else begin
          state_nx = S_LDMDR;
        end
      end
      S_WAIT: begin
        if (cnt == 4'd0) state_nx = S_LDMDR;
        else             cnt_nx   = cnt - 4'd1;
      end
      S_LDMDR: begin
        ldMDR = 1'b1;
        if (we_q) begin
          bus_out   = wdata_q;
          bus_drive = 1'b1;
          state_nx  = S_WRITE;
        end else begin
          selMDR   = 1'b1;
          state_nx = S_RESP;
        end
      end
      S_WRITE: begin
        memWE    = 1'b1;
        state_nx = S_RESP;
      end
      S_RESP: begin
        rsp_valid = 1'b1;
        if (!we_q) rsp_rdata = mdrOut;
        state_nx = S_IDLE;
      end
      S_ERR: begin
        rsp_valid = 1'b1;
        rsp_err   = 1'b1;
        state_nx  = S_IDLE;
      end
      default: state_nx = S_IDLE;
    endcase
  end

endmodule
